// File: rtl/uart_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_dispatcher
//  Description : Assembles an ASCII line from the UART RX stream, matches a
//                command name, decodes hex parameters, dispatches to executors
//                and streams an "OK HH" / "ER EE" status line to the UART TX.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_dispatcher #(
    parameter int NAME_LEN        = 10,
    parameter int NUM_CMDS        = 5,
    parameter logic [NUM_CMDS*NAME_LEN*8-1:0] CMD_TABLE =
        {"pb_i_write", "pb_i__read", "pb_adc4_16", "pb_adc4_08", "test______"},
    parameter int MAX_PARAM_BYTES = 5,
    parameter int TIMEOUT_CYCLES  = 27000000,
    localparam int ID_W           = $clog2(NUM_CMDS),
    localparam int CNT_W          = $clog2(MAX_PARAM_BYTES + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_data,
    output logic                         rx_ready,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [ID_W-1:0]              cmd_id,
    output logic [8*MAX_PARAM_BYTES-1:0] cmd_params,
    output logic [CNT_W-1:0]             cmd_param_count,
    input  logic                         exec_done,
    input  logic [7:0]                   exec_status,
    output logic                         tx_valid,
    output logic [7:0]                   tx_data,
    input  logic                         tx_ready,
    output logic                         busy
);

    localparam int LINE_MAX = NAME_LEN + 1 + 2*MAX_PARAM_BYTES;
    localparam int LEN_W    = $clog2(LINE_MAX + 1);
    localparam int DIG_W    = $clog2(2*MAX_PARAM_BYTES + 1);
    localparam int TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] c_RECV      = 3'd0;
    localparam logic [2:0] c_DRAIN     = 3'd1;
    localparam logic [2:0] c_CHECK     = 3'd2;
    localparam logic [2:0] c_MATCH     = 3'd3;
    localparam logic [2:0] c_DECODE    = 3'd4;
    localparam logic [2:0] c_DISPATCH  = 3'd5;
    localparam logic [2:0] c_WAIT_DONE = 3'd6;
    localparam logic [2:0] c_RESP      = 3'd7;

    localparam logic [7:0]       c_CR        = 8'h0D;
    localparam logic [7:0]       c_LF        = 8'h0A;
    localparam logic [LEN_W-1:0] c_LINE_MAX  = LEN_W'(LINE_MAX);
    localparam logic [LEN_W-1:0] c_NAME_P1   = LEN_W'(NAME_LEN + 1);
    localparam logic [ID_W-1:0]  c_LAST_ID   = ID_W'(NUM_CMDS - 1);
    localparam logic [TMR_W-1:0] c_TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]                   r_state;
    logic                         r_rx_en;
    logic [7:0]                   r_buf [LINE_MAX];
    logic [LEN_W-1:0]             r_len;
    logic [LEN_W-1:0]             r_pos;
    logic [ID_W-1:0]              r_k;
    logic [DIG_W-1:0]             r_ndig;
    logic                         r_bad;
    logic                         r_ok;
    logic [7:0]                   r_code;
    logic [2:0]                   r_tidx;
    logic [TMR_W-1:0]             r_timer;
    logic [ID_W-1:0]              r_cmd_id;
    logic [8*MAX_PARAM_BYTES-1:0] r_params;
    logic [CNT_W-1:0]             r_count;

    logic                         w_rx_hs;
    logic [NAME_LEN*8-1:0]        w_name;
    logic [NAME_LEN*8-1:0]        w_entry;
    logic [7:0]                   w_char;
    logic [3:0]                   w_nib;
    logic                         w_hex_ok;
    logic [7:0]                   w_tx_byte;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // rx_ready is held off for the first clock after reset releases
    assign rx_ready        = r_rx_en && ((r_state == c_RECV) || (r_state == c_DRAIN));
    assign w_rx_hs         = rx_valid && rx_ready;
    assign cmd_valid       = (r_state == c_DISPATCH);
    assign tx_valid        = (r_state == c_RESP);
    assign busy            = (r_state != c_RECV);
    assign cmd_id          = r_cmd_id;
    assign cmd_params      = r_params;
    assign cmd_param_count = r_count;
    assign tx_data         = (r_state == c_RESP) ? w_tx_byte : 8'h00;

    always_comb begin
        w_name  = '0;
        w_entry = '0;
        for (int j = 0; j < NAME_LEN; j++) begin
            w_name[(NAME_LEN-1-j)*8 +: 8] = r_buf[j];
        end
        for (int k = 0; k < NUM_CMDS; k++) begin
            if (r_k == ID_W'(k)) begin
                w_entry = CMD_TABLE[(NUM_CMDS-1-k)*NAME_LEN*8 +: NAME_LEN*8];
            end
        end
    end

    always_comb begin
        w_char   = r_buf[r_pos];
        w_nib    = 4'h0;
        w_hex_ok = 1'b1;
        if (w_char >= "0" && w_char <= "9") begin
            w_nib = w_char[3:0];
        end else if ((w_char >= "a" && w_char <= "f") || (w_char >= "A" && w_char <= "F")) begin
            w_nib = w_char[3:0] + 4'd9;
        end else begin
            w_hex_ok = 1'b0;
        end
    end

    always_comb begin
        w_tx_byte = 8'h00;
        case (r_tidx)
            3'd0:    w_tx_byte = r_ok ? "O" : "E";
            3'd1:    w_tx_byte = r_ok ? "K" : "R";
            3'd2:    w_tx_byte = " ";
            3'd3:    w_tx_byte = f_hex(r_code[7:4]);
            3'd4:    w_tx_byte = f_hex(r_code[3:0]);
            3'd5:    w_tx_byte = c_CR;
            3'd6:    w_tx_byte = c_LF;
            default: w_tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (r_state == c_RECV && w_rx_hs && rx_data != c_CR && rx_data != c_LF
            && r_len != c_LINE_MAX) begin
            r_buf[r_len] <= rx_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= c_RECV;
            r_rx_en  <= 1'b0;
            r_len    <= '0;
            r_pos    <= '0;
            r_k      <= '0;
            r_ndig   <= '0;
            r_bad    <= 1'b0;
            r_ok     <= 1'b0;
            r_code   <= 8'h00;
            r_tidx   <= 3'd0;
            r_timer  <= '0;
            r_cmd_id <= '0;
            r_params <= '0;
            r_count  <= '0;
        end else begin
            r_rx_en <= 1'b1;
            case (r_state)
                c_RECV: begin
                    if (w_rx_hs) begin
                        if (rx_data == c_LF) begin
                            if (r_len != '0) r_state <= c_CHECK;
                        end else if (rx_data != c_CR) begin
                            if (r_len == c_LINE_MAX) begin
                                r_state <= c_DRAIN;
                                r_ok    <= 1'b0;
                                r_code  <= 8'h03;
                            end else begin
                                r_len <= r_len + 1'b1;
                            end
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_rx_hs && rx_data == c_LF) r_state <= c_RESP;
                end
                c_CHECK: begin
                    if (r_len < c_NAME_P1 || r_buf[NAME_LEN] != ",") begin
                        r_state <= c_RESP;
                        r_ok    <= 1'b0;
                        r_code  <= 8'h04;
                    end else begin
                        r_state <= c_MATCH;
                        r_k     <= '0;
                    end
                end
                c_MATCH: begin
                    if (w_name == w_entry) begin
                        r_cmd_id <= r_k;
                        r_state  <= c_DECODE;
                        r_pos    <= c_NAME_P1;
                        r_ndig   <= '0;
                        r_bad    <= 1'b0;
                    end else if (r_k == c_LAST_ID) begin
                        r_state <= c_RESP;
                        r_ok    <= 1'b0;
                        r_code  <= 8'h01;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                c_DECODE: begin
                    if (r_pos == r_len) begin
                        if (r_bad) begin
                            r_state <= c_RESP;
                            r_ok    <= 1'b0;
                            r_code  <= 8'h02;
                        end else if (r_ndig[0]) begin
                            r_state <= c_RESP;
                            r_ok    <= 1'b0;
                            r_code  <= 8'h05;
                        end else begin
                            r_count <= CNT_W'(r_ndig[DIG_W-1:1]);
                            r_state <= c_DISPATCH;
                        end
                    end else begin
                        r_pos <= r_pos + 1'b1;
                        if (!w_hex_ok) begin
                            r_bad <= 1'b1;
                        end else if (!r_bad) begin
                            // byte index is ndig/2; even digit is the high nibble
                            if (!r_ndig[0]) r_params[{r_ndig[DIG_W-1:1], 3'b100} +: 4] <= w_nib;
                            else            r_params[{r_ndig[DIG_W-1:1], 3'b000} +: 4] <= w_nib;
                            r_ndig <= r_ndig + 1'b1;
                        end
                    end
                end
                c_DISPATCH: begin
                    if (cmd_ready) begin
                        if (exec_done) begin
                            r_state <= c_RESP;
                            r_ok    <= 1'b1;
                            r_code  <= exec_status;
                        end else begin
                            r_state <= c_WAIT_DONE;
                            r_timer <= '0;
                        end
                    end
                end
                c_WAIT_DONE: begin
                    if (exec_done) begin
                        r_state <= c_RESP;
                        r_ok    <= 1'b1;
                        r_code  <= exec_status;
                    end else if (r_timer == c_TMO_LAST) begin
                        r_state <= c_RESP;
                        r_ok    <= 1'b0;
                        r_code  <= 8'h06;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_RESP: begin
                    if (tx_ready) begin
                        if (r_tidx == 3'd6) begin
                            r_state  <= c_RECV;
                            r_tidx   <= 3'd0;
                            r_len    <= '0;
                            r_params <= '0;
                        end else begin
                            r_tidx <= r_tidx + 1'b1;
                        end
                    end
                end
                default: r_state <= c_RECV;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_dispatcher.md
Name: uart_cmd_dispatcher

Overview:
- Parametrised successor to the top-level ASCII command handler.
- Accepts a byte stream from the UART RX FIFO and assembles one line. Matches the command name against a parameter table of NUM_CMDS entries, then decodes up to MAX_PARAM_BYTES hex-encoded bytes.
- Dispatches the command to executor state machines over a valid/ready handshake and waits for completion.
- Streams a fixed-format ASCII status line to the UART TX FIFO.

Parameters:
- NAME_LEN, 10: command-name characters before the comma.
- NUM_CMDS, 5: entries in CMD_TABLE.
- CMD_TABLE, {"pb_i_write","pb_i__read","pb_adc4_16","pb_adc4_08","test______"}: NUM_CMDS*NAME_LEN*8 bits. Entry k = CMD_TABLE[(NUM_CMDS-1-k)*NAME_LEN*8 +: NAME_LEN*8], first char in MSB byte.
- MAX_PARAM_BYTES, 5: maximum decoded parameter bytes.
- TIMEOUT_CYCLES, 27000000: executor completion timeout, in clocks.
- Derived localparams:
  - LINE_MAX = NAME_LEN+1+2*MAX_PARAM_BYTES.
  - ID_W = $clog2(NUM_CMDS).
  - CNT_W = $clog2(MAX_PARAM_BYTES+1).

Ports:
- clock  in  1  system clock (27 MHz).
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  RX byte available.
- rx_data  in  8  RX byte.
- rx_ready  out  1  RX byte consumed when rx_valid&&rx_ready.
- cmd_valid  out  1  command presented to executors.
- cmd_ready  in  1  executor accepts command.
- cmd_id  out  ID_W  matched table index.
- cmd_params  out  8*MAX_PARAM_BYTES  byte i at [8*i +: 8]; unused bytes zero.
- cmd_param_count  out  CNT_W  number of decoded bytes.
- exec_done  in  1  single-cycle completion pulse.
- exec_status  in  8  status byte, valid with exec_done.
- tx_valid  out  1  response byte available.
- tx_data  out  8  response byte.
- tx_ready  in  1  TX FIFO accepts byte.
- busy  out  1  high in every state except RECV.

Behaviour:
- Reset (async, any state):
  - rx_ready, cmd_valid, tx_valid and busy go to 0; cmd_id, cmd_params, cmd_param_count and tx_data go to 0.
  - Line buffer index and timeout counter clear; state = RECV.
  - rx_ready rises the first clock after reset deasserts.
- States: RECV, DRAIN, CHECK, MATCH, DECODE, DISPATCH, WAIT_DONE, RESP.
- RECV:
  - rx_ready=1; one byte stored per handshake.
  - CR (0x0D) is discarded.
  - LF (0x0A) with length 0 is ignored; no response.
  - LF with length>0 -> CHECK.
  - A byte that would be LINE_MAX+1 -> DRAIN; error=03.
- DRAIN: rx_ready=1; discard bytes until LF -> RESP.
- CHECK: length<NAME_LEN+1 or buf[NAME_LEN]!="," -> RESP, error 04; else -> MATCH.
- MATCH:
  - Compare one table entry per clock, k=0..NUM_CMDS-1; first hit wins and sets cmd_id.
  - Hit -> DECODE.
  - No hit after NUM_CMDS clocks -> RESP, error 01.
- DECODE:
  - One character per clock, from buf[NAME_LEN+1] to end of line.
  - Accepts 0-9, a-f, A-F; high nibble first.
  - Any other character -> error 02.
  - Odd digit count -> error 05.
  - Error 02 has priority over 05.
  - Success -> DISPATCH with cmd_param_count = digits/2.
- DISPATCH:
  - cmd_valid=1; cmd_id, cmd_params and cmd_param_count held stable until cmd_valid&&cmd_ready, then -> WAIT_DONE.
- WAIT_DONE:
  - exec_done latches exec_status -> RESP (OK form).
  - exec_done in the same cycle as the cmd handshake is honoured.
  - exec_done in any other state is ignored.
  - Counter reaching TIMEOUT_CYCLES-1 -> RESP, error 06.
- RESP:
  - Emits 7 bytes: "OK "+HH+CR+LF or "ER "+EE+CR+LF.
  - Hex digits are uppercase.
  - tx_data stable while tx_valid&&!tx_ready; one byte per handshake.
  - After LF is accepted -> RECV, buffer cleared, cmd_params zeroed.
- rx_ready=0 outside RECV/DRAIN, so bytes back-pressure in the FIFO and none are lost.

Test Plan:
- Param decode: "pb_i_write,0102030405\n"; exec_done with status 0x56 one cycle after accept -> cmd_id=0, cmd_params=0x0504030201, count=5; tx "OK 56\r\n".
- Empty params: "pb_adc4_08,\r\n" -> cmd_id=3, count=0, params=0. Also: exec_done coincident with the cmd handshake, status 0xA0 -> "OK A0\r\n".
- Unknown and malformed lines:
  - "bogus_cmd_,00\n" -> no cmd_valid; "ER 01\r\n".
  - "pb_i_write;00\n" -> "ER 04\r\n".
  - "\n" alone -> no output.
- Hex errors:
  - "pb_i_write,01G2\n" -> "ER 02\r\n".
  - "pb_i_write,012\n" -> "ER 05\r\n".
  - "pb_i_write,0G2\n" -> "ER 02\r\n".
- Overflow: 40-char line + LF -> exactly one "ER 03\r\n" after LF, rx_ready=1 throughout. Next valid line is processed normally.
- Stall, timeout and reset: tx_ready low 20 cycles mid-response -> tx_data held. TIMEOUT_CYCLES=100 with no exec_done -> "ER 06\r\n" at cycle 100. reset pulsed in WAIT_DONE -> all outputs 0 immediately; the following line dispatches correctly.
